instruction_decode: RTL and testbench
=====================================

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter CLEAR_REGS, default "YES", meaning x1..x31 are zeroed on rst when "YES" and left unchanged on rst when "NO".
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_id_inf  input  if_id_inf_t  fetched {pc[31:0], pc_inc[31:0], instr[31:0]}.
REQ-005 SHALL have port stall  input  1  core stall, holds the ID/EX register.
REQ-006 SHALL have port flush  input  1  core flush, squashes the ID/EX register.
REQ-007 SHALL have port wb_wr_en  input  1  writeback register write enable.
REQ-008 SHALL have port wb_rd  input  5  writeback destination register.
REQ-009 SHALL have port wb_data  input  32  writeback data.
REQ-010 SHALL have port ex_is_load  input  1  instruction currently in EX is a load.
REQ-011 SHALL have port ex_rd  input  5  destination of the instruction in EX.
REQ-012 SHALL have port hazard_stall  output  1  load-use stall request to core/IF.
REQ-013 SHALL have port id_ex_inf  output  id_ex_inf_t  {pc, pc_inc, rs1_data, rs2_data, imm[31:0], rs1, rs2, rd[4:0], opcode[6:0], funct3[2:0], funct7b5}.

Function
REQ-014 SHALL hold a 32x32 register file written at posedge when wb_wr_en=1 and wb_rd!=0; writes to x0 ignored.
REQ-015 SHALL read rs1=instr[19:15] and rs2=instr[24:20] combinationally; x0 always reads 0.
REQ-016 SHALL generate imm by opcode: I-type for 0010011/0000011/1100111; S for 0100011; B for 1100011 (bit0=0); U for 0110111/0010111 (low 12 zero); J for 1101111 (bit0=0); 0 otherwise; all sign-extended from instr[31].
REQ-017 SHALL treat rs1 as used by all opcodes except 0110111, 0010111 and 1101111, and rs2 as used by 0110011, 0100011 and 1100011 only.
REQ-018 SHALL assert hazard_stall combinationally when ex_is_load=1, ex_rd!=0, and ex_rd matches a used source register.
REQ-019 SHALL update id_ex_inf at posedge with priority rst > flush > stall > hazard_stall > load.
REQ-020 SHALL clear id_ex_inf to all-zero on flush, which is the bubble encoding.
REQ-021 SHALL hold id_ex_inf unchanged on stall.
REQ-022 SHALL insert an all-zero bubble on hazard_stall, with the core holding IF so the same instr is re-presented next cycle.
REQ-023 SHALL otherwise capture the decoded fields, giving 1-cycle latency from if_id_inf to id_ex_inf.
REQ-024 SHALL perform the register-file write even when stall, flush or hazard_stall is asserted.

Reset
REQ-025 SHALL drive id_ex_inf to all-zero in the cycle after rst is sampled high.
REQ-026 SHALL zero x1..x31 on rst when CLEAR_REGS="YES" and ignore wb writes in reset cycles.
REQ-027 SHALL override flush, stall and in-flight hazards when rst is asserted mid-operation; hazard_stall remains combinational on its inputs.

Configuration
REQ-028 SHALL, with `ID_WB_BYPASS_EN defined, return wb_data for rs1_data/rs2_data when wb_wr_en=1, wb_rd!=0 and wb_rd equals that source (same-cycle write-through).
REQ-029 SHALL, without `ID_WB_BYPASS_EN, return the stored value and additionally assert hazard_stall when wb_wr_en=1, wb_rd!=0 and wb_rd matches a used source.

Verification
REQ-030 SHALL cover: wb write x5=0xDEADBEEF, then decode instr 0x00528333 (add x6,x5,x5) -> rs1_data=rs2_data=0xDEADBEEF, rd=6 one cycle later.
REQ-031 SHALL cover: wb write x0=0x1234, then decode an instruction reading x0 -> rs1_data=0.
REQ-032 SHALL cover: decode instr 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, opcode=1100011.
REQ-033 SHALL cover: ex_is_load=1 with ex_rd=7, decode instr 0x00038513 (addi x10,x7,0) -> hazard_stall=1 and a zero bubble; with ex_is_load=0 -> normal capture.
REQ-034 SHALL cover: same-cycle wb write x9=0x55 while decoding a read of x9 -> bypass build: rs1_data=0x55, no stall; non-bypass build: hazard_stall=1.
REQ-035 SHALL cover: stall and flush asserted together -> id_ex_inf all-zero; stall alone -> held; rst mid-stream -> all-zero and x1..x31 read 0.

Source files
------------

// File: rtl/instruction_decode.sv
// RV32I instruction decode stage: register file, immediate generation, load-use
// hazard detection and the ID/EX pipeline register. Optional macro: ID_WB_BYPASS_EN.
module instruction_decode #(
   parameter CLEAR_REGS = "YES"
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [95:0]  if_id_inf,
   input  logic         stall,
   input  logic         flush,
   input  logic         wb_wr_en,
   input  logic [4:0]   wb_rd,
   input  logic [31:0]  wb_data,
   input  logic         ex_is_load,
   input  logic [4:0]   ex_rd,
   output logic         hazard_stall,
   output logic [185:0] id_ex_inf
);

   // if_id_inf is packed {pc, pc_inc, instr}, most significant field first.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_inc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_inc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        funct7b5;
   } id_ex_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam bit CLEAR_EN = (CLEAR_REGS == "YES");

   if_id_t      fetch;
   id_ex_t      decoded;
   id_ex_t      id_ex_q;
   logic [31:0] regs [0:31];
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        rs1_used;
   logic        rs2_used;
   logic [31:0] rs1_stored;
   logic [31:0] rs2_stored;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imm;
   logic        wb_valid;
   logic        load_hazard;
   logic        wb_hazard;

   assign fetch    = if_id_t'(if_id_inf);
   assign instr    = fetch.instr;
   assign opcode   = instr[6:0];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign wb_valid = wb_wr_en && (wb_rd != 5'd0);

   // Writeback is independent of stall/flush/hazard; only reset blocks it.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (CLEAR_EN) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
         end
      end else if (wb_valid) begin
         regs[wb_rd] <= wb_data;
      end
   end

   assign rs1_stored = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_stored = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

   always_comb begin
      rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
      rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   end

`ifdef ID_WB_BYPASS_EN
   assign rs1_data  = (wb_valid && (wb_rd == rs1)) ? wb_data : rs1_stored;
   assign rs2_data  = (wb_valid && (wb_rd == rs2)) ? wb_data : rs2_stored;
   assign wb_hazard = 1'b0;
`else
   assign rs1_data  = rs1_stored;
   assign rs2_data  = rs2_stored;
   assign wb_hazard = wb_valid && ((rs1_used && (wb_rd == rs1)) ||
                                   (rs2_used && (wb_rd == rs2)));
`endif

   assign load_hazard  = ex_is_load && (ex_rd != 5'd0) &&
                         ((rs1_used && (ex_rd == rs1)) || (rs2_used && (ex_rd == rs2)));
   assign hazard_stall = load_hazard || wb_hazard;

   always_comb begin
      imm = 32'd0;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:                 imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:                imm = {{19{instr[31]}}, instr[31], instr[7],
                                          instr[30:25], instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         imm = {instr[31:12], 12'd0};
         OP_JAL:                   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                          instr[20], instr[30:21], 1'b0};
         default:                  imm = 32'd0;
      endcase
   end

   always_comb begin
      decoded          = '0;
      decoded.pc       = fetch.pc;
      decoded.pc_inc   = fetch.pc_inc;
      decoded.rs1_data = rs1_data;
      decoded.rs2_data = rs2_data;
      decoded.imm      = imm;
      decoded.rs1      = rs1;
      decoded.rs2      = rs2;
      decoded.rd       = instr[11:7];
      decoded.opcode   = opcode;
      decoded.funct3   = instr[14:12];
      decoded.funct7b5 = instr[30];
   end

   // All-zero is the bubble encoding, used for reset, flush and hazard insertion.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_q <= '0;
      end else if (flush) begin
         id_ex_q <= '0;
      end else if (stall) begin
         id_ex_q <= id_ex_q;
      end else if (hazard_stall) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= decoded;
      end
   end

   assign id_ex_inf = id_ex_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode; expectations follow the
// ID_WB_BYPASS_EN macro so the same bench serves both builds.
module tb_instruction_decode;

   logic         clk;
   logic         rst;
   logic [95:0]  if_id_inf;
   logic         stall;
   logic         flush;
   logic         wb_wr_en;
   logic [4:0]   wb_rd;
   logic [31:0]  wb_data;
   logic         ex_is_load;
   logic [4:0]   ex_rd;
   logic         hazard_stall;
   logic [185:0] id_ex_inf;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] I_NOP  = 32'h00000013;
   localparam logic [31:0] I_ADD  = 32'h00528333;
   localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
   localparam logic [31:0] I_LUI  = 32'hABCDE1B7;
   localparam logic [31:0] I_SW   = 32'h00602623;
   localparam logic [31:0] I_ADDI = 32'h00538513;
   localparam logic [31:0] I_X9   = 32'h00048593;
   localparam logic [31:0] I_X0   = 32'h00500093;

   wire [31:0] o_pc       = id_ex_inf[185:154];
   wire [31:0] o_pc_inc   = id_ex_inf[153:122];
   wire [31:0] o_rs1_data = id_ex_inf[121:90];
   wire [31:0] o_rs2_data = id_ex_inf[89:58];
   wire [31:0] o_imm      = id_ex_inf[57:26];
   wire [4:0]  o_rs1      = id_ex_inf[25:21];
   wire [4:0]  o_rs2      = id_ex_inf[20:16];
   wire [4:0]  o_rd       = id_ex_inf[15:11];
   wire [6:0]  o_opcode   = id_ex_inf[10:4];

   instruction_decode dut (
      .clk          (clk),
      .rst          (rst),
      .if_id_inf    (if_id_inf),
      .stall        (stall),
      .flush        (flush),
      .wb_wr_en     (wb_wr_en),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .hazard_stall (hazard_stall),
      .id_ex_inf    (id_ex_inf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
      if_id_inf = {pc, pc + 32'd4, instr};
   endtask

   task automatic quiet();
      stall = 0; flush = 0; wb_wr_en = 0; wb_rd = 0; wb_data = 0;
      ex_is_load = 0; ex_rd = 0;
   endtask

   task automatic test_reset();
      rst = 1; quiet(); drive(32'h0, I_NOP);
      step(); step();
      total++; if (id_ex_inf !== '0) begin bad++; $display("[TB] FAIL reset_idex: got %h want 0", id_ex_inf); end
      total++; if (hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_hazard: got %b want 0", hazard_stall); end
      rst = 0;
   endtask

   task automatic test_regfile();
      quiet(); drive(32'h0, I_NOP);
      wb_wr_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
      #1;
      total++; if (hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL wb_nop_hazard: got %b want 0", hazard_stall); end
      step();
      quiet(); drive(32'h100, I_ADD);
      step();
      total++; if (o_rs1_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL add_rs1_data: got %h want deadbeef", o_rs1_data); end
      total++; if (o_rs2_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL add_rs2_data: got %h want deadbeef", o_rs2_data); end
      total++; if (o_rd !== 5'd6) begin bad++; $display("[TB] FAIL add_rd: got %0d want 6", o_rd); end
      total++; if (o_opcode !== 7'b0110011) begin bad++; $display("[TB] FAIL add_opcode: got %b want 0110011", o_opcode); end
      total++; if (o_pc !== 32'h100 || o_pc_inc !== 32'h104) begin bad++; $display("[TB] FAIL add_pc: got %h/%h want 100/104", o_pc, o_pc_inc); end
      total++; if (o_imm !== 32'd0) begin bad++; $display("[TB] FAIL add_imm: got %h want 0", o_imm); end
   endtask

   task automatic test_x0();
      quiet(); drive(32'h200, I_NOP);
      wb_wr_en = 1; wb_rd = 0; wb_data = 32'h1234;
      step();
      wb_wr_en = 1; wb_rd = 0; wb_data = 32'h1234;
      drive(32'h204, I_X0);
      #1;
      total++; if (hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL x0_hazard: got %b want 0", hazard_stall); end
      step();
      total++; if (o_rs1_data !== 32'd0) begin bad++; $display("[TB] FAIL x0_read: got %h want 0", o_rs1_data); end
      total++; if (o_imm !== 32'd5 || o_rd !== 5'd1) begin bad++; $display("[TB] FAIL x0_addi: got imm %h rd %0d want 5 rd 1", o_imm, o_rd); end
      quiet();
   endtask

   task automatic test_imm();
      quiet(); drive(32'h300, I_BEQ);
      step();
      total++; if (o_imm !== 32'hFFFFFFFC) begin bad++; $display("[TB] FAIL beq_imm: got %h want fffffffc", o_imm); end
      total++; if (o_opcode !== 7'b1100011) begin bad++; $display("[TB] FAIL beq_opcode: got %b want 1100011", o_opcode); end
      drive(32'h304, I_LUI);
      step();
      total++; if (o_imm !== 32'hABCDE000 || o_rd !== 5'd3) begin bad++; $display("[TB] FAIL lui_imm: got %h rd %0d want abcde000 rd 3", o_imm, o_rd); end
      drive(32'h308, I_SW);
      step();
      total++; if (o_imm !== 32'h0000000C || o_rs2 !== 5'd6) begin bad++; $display("[TB] FAIL sw_imm: got %h rs2 %0d want c rs2 6", o_imm, o_rs2); end
   endtask

   task automatic test_load_use();
      quiet(); drive(32'h400, I_ADDI);
      ex_is_load = 1; ex_rd = 7;
      #1;
      total++; if (hazard_stall !== 1'b1) begin bad++; $display("[TB] FAIL load_use_hazard: got %b want 1", hazard_stall); end
      step();
      total++; if (id_ex_inf !== '0) begin bad++; $display("[TB] FAIL load_use_bubble: got %h want 0", id_ex_inf); end
      ex_rd = 5;
      #1;
      total++; if (hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL rs2_unused_hazard: got %b want 0", hazard_stall); end
      ex_rd = 0;
      #1;
      total++; if (hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL ex_rd0_hazard: got %b want 0", hazard_stall); end
      drive(32'h404, I_LUI); ex_rd = 27;
      #1;
      total++; if (hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL lui_rs1_unused: got %b want 0", hazard_stall); end
      drive(32'h400, I_ADDI); ex_is_load = 0; ex_rd = 7;
      #1;
      total++; if (hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL no_load_hazard: got %b want 0", hazard_stall); end
      step();
      total++; if (o_rd !== 5'd10 || o_rs1 !== 5'd7 || o_opcode !== 7'b0010011 || o_imm !== 32'd5) begin
         bad++; $display("[TB] FAIL addi_capture: got rd %0d rs1 %0d op %b imm %h want 10 7 0010011 5", o_rd, o_rs1, o_opcode, o_imm);
      end
      quiet();
   endtask

   task automatic test_wb_same_cycle();
      quiet(); drive(32'h500, I_X9);
      wb_wr_en = 1; wb_rd = 9; wb_data = 32'h55;
      #1;
`ifdef ID_WB_BYPASS_EN
      total++; if (hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL bypass_hazard: got %b want 0", hazard_stall); end
      step();
      total++; if (o_rs1_data !== 32'h55 || o_rd !== 5'd11) begin bad++; $display("[TB] FAIL bypass_data: got %h rd %0d want 55 rd 11", o_rs1_data, o_rd); end
      quiet();
`else
      total++; if (hazard_stall !== 1'b1) begin bad++; $display("[TB] FAIL wb_hazard: got %b want 1", hazard_stall); end
      step();
      total++; if (id_ex_inf !== '0) begin bad++; $display("[TB] FAIL wb_bubble: got %h want 0", id_ex_inf); end
      quiet();
      step();
      total++; if (o_rs1_data !== 32'h55 || o_rd !== 5'd11) begin bad++; $display("[TB] FAIL wb_retry_data: got %h rd %0d want 55 rd 11", o_rs1_data, o_rd); end
`endif
   endtask

   task automatic test_stall_flush();
      quiet(); drive(32'h600, I_ADD);
      step();
      stall = 1; drive(32'h604, I_BEQ);
      ex_is_load = 1; ex_rd = 5;
      drive(32'h604, I_ADD);
      step();
      total++; if (o_pc !== 32'h600 || o_rs1_data !== 32'hDEADBEEF || o_rd !== 5'd6) begin
         bad++; $display("[TB] FAIL stall_hold: got pc %h rs1 %h rd %0d want 600 deadbeef 6", o_pc, o_rs1_data, o_rd);
      end
      ex_is_load = 0; flush = 1;
      step();
      total++; if (id_ex_inf !== '0) begin bad++; $display("[TB] FAIL stall_flush: got %h want 0", id_ex_inf); end
      quiet();
   endtask

   task automatic test_reset_midstream();
      quiet(); drive(32'h700, I_ADD);
      step();
      rst = 1; stall = 1; ex_is_load = 1; ex_rd = 5;
      wb_wr_en = 1; wb_rd = 9; wb_data = 32'hCAFE;
      #1;
      total++; if (hazard_stall !== 1'b1) begin bad++; $display("[TB] FAIL rst_hazard_comb: got %b want 1", hazard_stall); end
      step();
      total++; if (id_ex_inf !== '0) begin bad++; $display("[TB] FAIL rst_mid_idex: got %h want 0", id_ex_inf); end
      rst = 0; quiet(); drive(32'h704, I_ADD);
      step();
      total++; if (o_rs1_data !== 32'd0 || o_rs2_data !== 32'd0) begin bad++; $display("[TB] FAIL rst_x5_clear: got %h/%h want 0/0", o_rs1_data, o_rs2_data); end
      drive(32'h708, I_X9);
      step();
      total++; if (o_rs1_data !== 32'd0) begin bad++; $display("[TB] FAIL rst_x9_clear: got %h want 0", o_rs1_data); end
   endtask

   initial begin
      rst = 1; quiet(); drive(32'h0, I_NOP);
      test_reset();
      test_regfile();
      test_x0();
      test_imm();
      test_load_use();
      test_wb_same_cycle();
      test_stall_flush();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
